msrv32_machine_csr_file: RTL and testbench

Machine-mode CSR file for the msrv32 core: holds trap state (mstatus, mie, mip, mtvec, mepc, mcause, mtval, mscratch) and the 64-bit cycle/instret counters. It sits in pipeline stage 2 and is driven by the machine-control trap FSM (set_epc/set_cause/mie_clear/mie_set/instret_inc). It returns interrupt-enable and pending bits to that FSM, trap and return targets to the PC mux, and CSR read data to the write-back path.

---
 rtl/msrv32_machine_csr_file.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_msrv32_machine_csr_file.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_machine_csr_file.sv
// Machine-mode CSR file for the msrv32 core, pipeline stage 2.
// Holds trap state and the 64-bit cycle/instret counters. Reads are
// combinational. Writes, trap updates and counter increments land on the
// rising clk_in edge.
module msrv32_machine_csr_file #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        i_or_e_in,
    input  logic        set_epc_in,
    input  logic        set_cause_in,
    input  logic        mie_clear_in,
    input  logic        mie_set_in,
    input  logic        instret_inc_in,
    input  logic        misaligned_exception_in,
    input  logic [3:0]  cause_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] iadder_in,
    input  logic        e_irq_in,
    input  logic        t_irq_in,
    input  logic        s_irq_in,
    input  logic [11:0] csr_addr_in,
    input  logic        csr_wr_en_in,
    input  logic [1:0]  csr_op_in,
    input  logic [31:0] csr_wdata_in,
    output logic [31:0] csr_data_out,
    output logic        illegal_csr_out,
    output logic        mie_out,
    output logic        meie_out,
    output logic        mtie_out,
    output logic        msie_out,
    output logic        meip_out,
    output logic        mtip_out,
    output logic        msip_out,
    output logic [31:0] epc_out,
    output logic [31:0] trap_address_out
);

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [1:0]  OP_RW = 2'b01;
    localparam logic [1:0]  OP_RS = 2'b10;
    localparam logic [1:0]  OP_RC = 2'b11;

    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

    // Architectural state
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic        mie_meie;
    logic        mie_mtie;
    logic        mie_msie;
    logic        mip_meip;
    logic        mip_mtip;
    logic        mip_msip;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic        mcause_int;
    logic [3:0]  mcause_code;
    logic [31:0] mtval;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    logic [31:0] mstatus_rd;
    logic [31:0] mie_rd;
    logic [31:0] mip_rd;
    logic [31:0] mcause_rd;
    logic [31:0] wr_val;
    logic        csr_writable;
    logic        wr_active;
    logic        wr_mstatus;
    logic        wr_mie;
    logic        wr_mtvec;
    logic        wr_mscratch;
    logic        wr_mepc;
    logic        wr_mcause;
    logic        wr_mtval;
    logic        wr_mcycle;
    logic        wr_mcycleh;
    logic        wr_minstret;
    logic        wr_minstreth;

    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
    assign mie_rd     = {20'b0, mie_meie, 3'b0, mie_mtie, 3'b0, mie_msie, 3'b0};
    assign mip_rd     = {20'b0, mip_meip, 3'b0, mip_mtip, 3'b0, mip_msip, 3'b0};
    assign mcause_rd  = {mcause_int, 27'b0, mcause_code};

    // Combinational read mux; also flags unimplemented and read-only addresses
    always_comb begin
        csr_data_out    = 32'h0;
        illegal_csr_out = 1'b0;
        csr_writable    = 1'b1;
        case (csr_addr_in)
            CSR_MSTATUS:   csr_data_out = mstatus_rd;
            CSR_MISA: begin
                csr_data_out = MISA_VALUE;
                csr_writable = 1'b0;
            end
            CSR_MIE:       csr_data_out = mie_rd;
            CSR_MTVEC:     csr_data_out = mtvec;
            CSR_MSCRATCH:  csr_data_out = mscratch;
            CSR_MEPC:      csr_data_out = mepc;
            CSR_MCAUSE:    csr_data_out = mcause_rd;
            CSR_MTVAL:     csr_data_out = mtval;
            CSR_MIP: begin
                csr_data_out = mip_rd;
                csr_writable = 1'b0;
            end
            CSR_MCYCLE:    csr_data_out = mcycle[31:0];
            CSR_MCYCLEH:   csr_data_out = mcycle[63:32];
            CSR_MINSTRET:  csr_data_out = minstret[31:0];
            CSR_MINSTRETH: csr_data_out = minstret[63:32];
            CSR_CYCLE: begin
                csr_data_out = mcycle[31:0];
                csr_writable = 1'b0;
            end
            CSR_CYCLEH: begin
                csr_data_out = mcycle[63:32];
                csr_writable = 1'b0;
            end
            CSR_INSTRET: begin
                csr_data_out = minstret[31:0];
                csr_writable = 1'b0;
            end
            CSR_INSTRETH: begin
                csr_data_out = minstret[63:32];
                csr_writable = 1'b0;
            end
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: begin
                csr_data_out = 32'h0;
                csr_writable = 1'b0;
            end
            default: begin
                illegal_csr_out = 1'b1;
                csr_writable    = 1'b0;
            end
        endcase
    end

    // Read-modify-write value for RW/RS/RC built from the current read value
    always_comb begin
        case (csr_op_in)
            OP_RW:   wr_val = csr_wdata_in;
            OP_RS:   wr_val = csr_data_out | csr_wdata_in;
            OP_RC:   wr_val = csr_data_out & ~csr_wdata_in;
            default: wr_val = csr_data_out;
        endcase
    end

    assign wr_active    = csr_wr_en_in && (csr_op_in != 2'b00) && csr_writable;
    assign wr_mstatus   = wr_active && (csr_addr_in == CSR_MSTATUS);
    assign wr_mie       = wr_active && (csr_addr_in == CSR_MIE);
    assign wr_mtvec     = wr_active && (csr_addr_in == CSR_MTVEC);
    assign wr_mscratch  = wr_active && (csr_addr_in == CSR_MSCRATCH);
    assign wr_mepc      = wr_active && (csr_addr_in == CSR_MEPC);
    assign wr_mcause    = wr_active && (csr_addr_in == CSR_MCAUSE);
    assign wr_mtval     = wr_active && (csr_addr_in == CSR_MTVAL);
    assign wr_mcycle    = wr_active && (csr_addr_in == CSR_MCYCLE);
    assign wr_mcycleh   = wr_active && (csr_addr_in == CSR_MCYCLEH);
    assign wr_minstret  = wr_active && (csr_addr_in == CSR_MINSTRET);
    assign wr_minstreth = wr_active && (csr_addr_in == CSR_MINSTRETH);

    // mstatus: trap entry/return updates take precedence over a CSR write
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
        end else if (mie_clear_in) begin
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (mie_set_in) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (wr_mstatus) begin
            mstatus_mie  <= wr_val[3];
            mstatus_mpie <= wr_val[7];
        end
    end

    // mie enable bits and the one-cycle-delayed interrupt pending bits
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            mie_meie <= 1'b0;
            mie_mtie <= 1'b0;
            mie_msie <= 1'b0;
            mip_meip <= 1'b0;
            mip_mtip <= 1'b0;
            mip_msip <= 1'b0;
        end else begin
            if (wr_mie) begin
                mie_meie <= wr_val[11];
                mie_mtie <= wr_val[7];
                mie_msie <= wr_val[3];
            end
            mip_meip <= e_irq_in;
            mip_mtip <= t_irq_in;
            mip_msip <= s_irq_in;
        end
    end

    // Plain read/write registers: mtvec and mscratch
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            mtvec    <= MTVEC_RESET;
            mscratch <= 32'h0;
        end else begin
            if (wr_mtvec)
                mtvec <= wr_val;
            if (wr_mscratch)
                mscratch <= wr_val;
        end
    end

    // Trap capture of mepc/mcause/mtval; the trap FSM wins over a CSR write
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            mepc        <= 32'h0;
            mcause_int  <= 1'b0;
            mcause_code <= 4'h0;
            mtval       <= 32'h0;
        end else begin
            if (set_epc_in)
                mepc <= pc_in & 32'hFFFF_FFFC;
            else if (wr_mepc)
                mepc <= wr_val & 32'hFFFF_FFFC;

            if (set_cause_in) begin
                mcause_int  <= i_or_e_in;
                mcause_code <= cause_in;
                mtval       <= misaligned_exception_in ? iadder_in : 32'h0;
            end else begin
                if (wr_mcause) begin
                    mcause_int  <= wr_val[31];
                    mcause_code <= wr_val[3:0];
                end
                if (wr_mtval)
                    mtval <= wr_val;
            end
        end
    end

    // mcycle: free-running; a write to one half blocks the carry that cycle
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            mcycle <= 64'h0;
        end else begin
            if (wr_mcycle)
                mcycle[31:0] <= wr_val;
            else
                mcycle[31:0] <= mcycle[31:0] + 32'd1;

            if (wr_mcycleh)
                mcycle[63:32] <= wr_val;
            else if (!wr_mcycle && (mcycle[31:0] == 32'hFFFF_FFFF))
                mcycle[63:32] <= mcycle[63:32] + 32'd1;
        end
    end

    // minstret: counts retired instructions, same write/carry rules as mcycle
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            minstret <= 64'h0;
        end else begin
            if (wr_minstret)
                minstret[31:0] <= wr_val;
            else if (instret_inc_in)
                minstret[31:0] <= minstret[31:0] + 32'd1;

            if (wr_minstreth)
                minstret[63:32] <= wr_val;
            else if (instret_inc_in && !wr_minstret &&
                     (minstret[31:0] == 32'hFFFF_FFFF))
                minstret[63:32] <= minstret[63:32] + 32'd1;
        end
    end

    assign mie_out  = mstatus_mie;
    assign meie_out = mie_meie;
    assign mtie_out = mie_mtie;
    assign msie_out = mie_msie;
    assign meip_out = mip_meip;
    assign mtip_out = mip_mtip;
    assign msip_out = mip_msip;
    assign epc_out  = mepc;

    // Vectored mode adds 4*cause for interrupts; everything else uses the base
    always_comb begin
        if ((mtvec[1:0] == 2'b01) && mcause_int)
            trap_address_out = {mtvec[31:2], 2'b00} + {26'b0, mcause_code, 2'b00};
        else
            trap_address_out = {mtvec[31:2], 2'b00};
    end

endmodule

// File: tb/tb_msrv32_machine_csr_file.sv
// Directed self-checking bench for msrv32_machine_csr_file.
module tb_msrv32_machine_csr_file;

    localparam logic [31:0] MTVEC_RESET = 32'h0000_0000;

    logic        clk_in;
    logic        reset_in;
    logic        i_or_e_in;
    logic        set_epc_in;
    logic        set_cause_in;
    logic        mie_clear_in;
    logic        mie_set_in;
    logic        instret_inc_in;
    logic        misaligned_exception_in;
    logic [3:0]  cause_in;
    logic [31:0] pc_in;
    logic [31:0] iadder_in;
    logic        e_irq_in;
    logic        t_irq_in;
    logic        s_irq_in;
    logic [11:0] csr_addr_in;
    logic        csr_wr_en_in;
    logic [1:0]  csr_op_in;
    logic [31:0] csr_wdata_in;
    logic [31:0] csr_data_out;
    logic        illegal_csr_out;
    logic        mie_out;
    logic        meie_out;
    logic        mtie_out;
    logic        msie_out;
    logic        meip_out;
    logic        mtip_out;
    logic        msip_out;
    logic [31:0] epc_out;
    logic [31:0] trap_address_out;

    int checks = 0;
    int errors = 0;

    msrv32_machine_csr_file #(.MTVEC_RESET(MTVEC_RESET)) dut (
        .clk_in                  (clk_in),
        .reset_in                (reset_in),
        .i_or_e_in               (i_or_e_in),
        .set_epc_in              (set_epc_in),
        .set_cause_in            (set_cause_in),
        .mie_clear_in            (mie_clear_in),
        .mie_set_in              (mie_set_in),
        .instret_inc_in          (instret_inc_in),
        .misaligned_exception_in (misaligned_exception_in),
        .cause_in                (cause_in),
        .pc_in                   (pc_in),
        .iadder_in               (iadder_in),
        .e_irq_in                (e_irq_in),
        .t_irq_in                (t_irq_in),
        .s_irq_in                (s_irq_in),
        .csr_addr_in             (csr_addr_in),
        .csr_wr_en_in            (csr_wr_en_in),
        .csr_op_in               (csr_op_in),
        .csr_wdata_in            (csr_wdata_in),
        .csr_data_out            (csr_data_out),
        .illegal_csr_out         (illegal_csr_out),
        .mie_out                 (mie_out),
        .meie_out                (meie_out),
        .mtie_out                (mtie_out),
        .msie_out                (msie_out),
        .meip_out                (meip_out),
        .mtip_out                (mtip_out),
        .msip_out                (msip_out),
        .epc_out                 (epc_out),
        .trap_address_out        (trap_address_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Advance past the next rising edge; inputs change and outputs are sampled here
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Combinational read of one CSR
    task automatic rd(input logic [11:0] addr, input string tag, input logic [31:0] exp);
        csr_addr_in = addr;
        #1;
        check(tag, csr_data_out, exp);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] data);
        csr_addr_in  = addr;
        csr_op_in    = op;
        csr_wdata_in = data;
        csr_wr_en_in = 1'b1;
    endtask

    task automatic wr_off();
        csr_wr_en_in = 1'b0;
        csr_op_in    = 2'b00;
        csr_wdata_in = 32'h0;
    endtask

    initial begin
        reset_in = 1'b1;
        i_or_e_in = 1'b0;
        set_epc_in = 1'b0;
        set_cause_in = 1'b0;
        mie_clear_in = 1'b0;
        mie_set_in = 1'b0;
        instret_inc_in = 1'b0;
        misaligned_exception_in = 1'b0;
        cause_in = 4'h0;
        pc_in = 32'h0;
        iadder_in = 32'h0;
        e_irq_in = 1'b0;
        t_irq_in = 1'b0;
        s_irq_in = 1'b0;
        csr_addr_in = 12'h000;
        wr_off();

        tick();
        tick();
        reset_in = 1'b0;

        // Reset state
        rd(12'h305, "rst_mtvec", MTVEC_RESET);
        check("rst_mtvec_legal", {31'b0, illegal_csr_out}, 32'h0);
        rd(12'h300, "rst_mstatus", 32'h0000_1800);
        rd(12'h304, "rst_mie", 32'h0);
        rd(12'h7C0, "unimpl_data", 32'h0);
        check("unimpl_illegal", {31'b0, illegal_csr_out}, 32'h1);
        check("rst_trap_addr", trap_address_out, {MTVEC_RESET[31:2], 2'b00});
        check("rst_epc", epc_out, 32'h0);
        check("rst_mie_out", {31'b0, mie_out}, 32'h0);
        rd(12'h301, "misa", 32'h4000_0100);
        rd(12'hF14, "mhartid", 32'h0);

        // Vectored mtvec with an interrupt cause
        wr(12'h305, 2'b01, 32'h0000_1001);
        i_or_e_in = 1'b1;
        cause_in = 4'hB;
        set_cause_in = 1'b1;
        tick();
        wr_off();
        set_cause_in = 1'b0;
        rd(12'h305, "mtvec_rw", 32'h0000_1001);
        rd(12'h342, "mcause_int", 32'h8000_000B);
        check("trap_vectored", trap_address_out, 32'h0000_102C);
        i_or_e_in = 1'b0;
        set_cause_in = 1'b1;
        tick();
        set_cause_in = 1'b0;
        check("trap_exception", trap_address_out, 32'h0000_1000);
        rd(12'h342, "mcause_exc", 32'h0000_000B);

        // misa write ignored, mscratch round trip
        wr(12'h301, 2'b01, 32'hFFFF_FFFF);
        tick();
        wr(12'h340, 2'b01, 32'h1234_5678);
        tick();
        wr_off();
        rd(12'h301, "misa_ro", 32'h4000_0100);
        rd(12'h340, "mscratch", 32'h1234_5678);

        // MIE set, then trap entry and mret
        wr(12'h300, 2'b10, 32'h0000_0008);
        tick();
        wr_off();
        rd(12'h300, "mstatus_rs", 32'h0000_1808);
        check("mie_out_set", {31'b0, mie_out}, 32'h1);
        mie_clear_in = 1'b1;
        tick();
        mie_clear_in = 1'b0;
        rd(12'h300, "mstatus_clear", 32'h0000_1880);
        check("mie_out_clear", {31'b0, mie_out}, 32'h0);
        mie_set_in = 1'b1;
        tick();
        mie_set_in = 1'b0;
        rd(12'h300, "mstatus_mret", 32'h0000_1888);

        // Misaligned trap beats a simultaneous CSRRW to mepc
        pc_in = 32'h0000_0206;
        iadder_in = 32'h0000_0103;
        misaligned_exception_in = 1'b1;
        cause_in = 4'h0;
        i_or_e_in = 1'b0;
        set_epc_in = 1'b1;
        set_cause_in = 1'b1;
        wr(12'h341, 2'b01, 32'hDEAD_BEEF);
        tick();
        wr_off();
        set_epc_in = 1'b0;
        set_cause_in = 1'b0;
        misaligned_exception_in = 1'b0;
        rd(12'h341, "mepc_trap", 32'h0000_0204);
        check("epc_out", epc_out, 32'h0000_0204);
        rd(12'h343, "mtval_trap", 32'h0000_0103);
        rd(12'h342, "mcause_trap", 32'h0000_0000);

        // mcycle low-half write, carry into high two edges later
        wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
        tick();
        wr_off();
        rd(12'hB00, "mcycle_written", 32'hFFFF_FFFF);
        rd(12'hB80, "mcycleh_no_carry", 32'h0);
        tick();
        rd(12'hB80, "mcycleh_carry", 32'h1);
        rd(12'hB00, "mcycle_wrap", 32'h0);
        rd(12'hC80, "cycleh_shadow", 32'h1);

        // minstret counting, RC clear beats increment, low-to-high carry
        instret_inc_in = 1'b1;
        tick();
        tick();
        tick();
        rd(12'hB02, "minstret_cnt", 32'h3);
        rd(12'hC02, "instret_shadow", 32'h3);
        wr(12'hB02, 2'b11, 32'hFFFF_FFFF);
        tick();
        wr_off();
        instret_inc_in = 1'b0;
        rd(12'hB02, "minstret_rc", 32'h0);
        wr(12'hB02, 2'b01, 32'hFFFF_FFFF);
        tick();
        wr_off();
        instret_inc_in = 1'b1;
        tick();
        instret_inc_in = 1'b0;
        rd(12'hB02, "minstret_wrap", 32'h0);
        rd(12'hB82, "minstreth_carry", 32'h1);

        // Timer interrupt pending lags by one cycle and lasts one cycle
        t_irq_in = 1'b1;
        tick();
        t_irq_in = 1'b0;
        check("mtip_high", {31'b0, mtip_out}, 32'h1);
        rd(12'h344, "mip_mtip", 32'h0000_0080);
        tick();
        check("mtip_low", {31'b0, mtip_out}, 32'h0);
        rd(12'h344, "mip_clear", 32'h0);
        wr(12'h304, 2'b10, 32'h0000_0080);
        tick();
        wr_off();
        check("mtie_out", {31'b0, mtie_out}, 32'h1);
        rd(12'h304, "mie_rs", 32'h0000_0080);

        // Reset in the middle of activity
        reset_in = 1'b1;
        wr(12'h305, 2'b01, 32'h0000_4444);
        instret_inc_in = 1'b1;
        tick();
        reset_in = 1'b0;
        wr_off();
        instret_inc_in = 1'b0;
        rd(12'h305, "mid_rst_mtvec", MTVEC_RESET);
        rd(12'h300, "mid_rst_mstatus", 32'h0000_1800);
        rd(12'hB00, "mid_rst_mcycle", 32'h0);
        rd(12'hB82, "mid_rst_minstreth", 32'h0);
        check("mid_rst_epc", epc_out, 32'h0);
        check("mid_rst_mtie", {31'b0, mtie_out}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
